// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC sequencer: FSM state encoding,
// ALU opcodes and default sizing constants.
package fir_pkg;

  localparam int NTAPS_DEF   = 8;
  localparam int ALU_LAT_DEF = 2;
  localparam int ACC_W_DEF   = 35;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_MUL = 2'b01;
  localparam logic [1:0] ALU_OP_NOP = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

  // Width of the shared tap/drain counter: must reach max(NTAPS, ALU_LAT).
  function automatic int cnt_width(input int ntaps, input int alu_lat);
    return $clog2(((ntaps > alu_lat) ? ntaps : alu_lat) + 1);
  endfunction

endpackage

// File: rtl/fir_coef_rf.sv
// NTAPS x 16 coefficient register file. Writes land only while en_i is
// high (sequencer idle) and the address is in range; reads are
// combinational by tap index.
module fir_coef_rf
  import fir_pkg::*;
#(
  parameter  int NTAPS = NTAPS_DEF,
  localparam int AW    = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          en_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  localparam logic [AW:0] NTAPS_W = (AW+1)'(NTAPS);

  logic [15:0] coef_q [NTAPS];
  logic        wr_ok;
  logic        rd_ok;

  assign wr_ok = we_i && en_i && ({1'b0, waddr_i} < NTAPS_W);
  assign rd_ok = ({1'b0, raddr_i} < NTAPS_W);

  // Coefficient storage: cleared on reset, written by a gated strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else if (wr_ok) begin
      coef_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    rdata_o = '0;
    if (rd_ok) rdata_o = coef_q[raddr_i];
  end

endmodule

// File: rtl/fir_mac_seq.sv
// FIR MAC sequencer: accepts one sample, issues NTAPS unsigned multiplies
// to the shared pipelined ALU, accumulates the returned products and
// presents one FIR result.
// Optional build macro FIR_SAT_EN: saturate the result to 32 bits and
// raise out_sat when the accumulator exceeds 32'hFFFF_FFFF.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready/coef_ready are high only in IDLE and do not depend on in_valid;
// out_valid is high only in OUT and out_data is held stable until
// out_ready is seen with it.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter  int NTAPS   = NTAPS_DEF,
  parameter  int ALU_LAT = ALU_LAT_DEF,
  parameter  int ACC_W   = ACC_W_DEF,
  localparam int AW      = $clog2(NTAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [15:0]      coef_wdata,
  output logic             coef_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic [1:0]       alu_op_sel,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  input  logic [31:0]      alu_result,
  output fir_state_e       dbg_state_o
);

  localparam int CNT_W = cnt_width(NTAPS, ALU_LAT);
  localparam logic [CNT_W-1:0] LAST_TAP   = CNT_W'(NTAPS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(ALU_LAT - 1);
`ifdef FIR_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(33'h0_FFFF_FFFF);
`endif

  fir_state_e       state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [ALU_LAT-1:0] tag_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      x_q [NTAPS];
  logic [15:0]      alu_a_q, alu_b_q;
  logic [15:0]      coef_rd;
  logic [AW-1:0]    tap_idx;
  logic             accept;
  logic             issue;

  assign accept  = (state_q == IDLE) && in_valid;
  assign issue   = (state_q == ISSUE);
  assign tap_idx = k_q[AW-1:0];
  assign dbg_state_o = state_q;

  fir_coef_rf #(.NTAPS(NTAPS)) u_coef_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (coef_we),
    .en_i    (coef_ready),
    .waddr_i (coef_addr),
    .wdata_i (coef_wdata),
    .raddr_i (tap_idx),
    .rdata_o (coef_rd)
  );

  // State register and the shared tap / drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: one ISSUE cycle per tap, ALU_LAT DRAIN cycles, then OUT.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ISSUE;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (k_q == LAST_TAP) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (k_q == LAST_DRAIN) begin
          state_d = OUT;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshakes, ALU command and the presented result.
  always_comb begin
    in_ready   = (state_q == IDLE);
    coef_ready = (state_q == IDLE);
    out_valid  = (state_q == OUT);
    out_data   = '0;
    out_sat    = 1'b0;
    alu_op_sel = ALU_OP_NOP;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    if (state_q == ISSUE) begin
      alu_op_sel = ALU_OP_MUL;
      alu_a      = x_q[tap_idx];
      alu_b      = coef_rd;
    end else if (state_q == DRAIN) begin
      // The ALU samples op_sel in its second stage, so keep MUL while draining.
      alu_op_sel = ALU_OP_MUL;
    end
    if (state_q == OUT) begin
`ifdef FIR_SAT_EN
      if (acc_q > SAT_MAX) begin
        out_data = SAT_MAX;
        out_sat  = 1'b1;
      end else begin
        out_data = acc_q;
      end
`else
      out_data = acc_q;
`endif
    end
  end

  // Operand hold registers so the ALU inputs keep their last values when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q <= '0;
      alu_b_q <= '0;
    end else begin
      alu_a_q <= alu_a;
      alu_b_q <= alu_b;
    end
  end

  // Sample delay line: newest sample in x_q[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= in_data;
      for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  // Accumulator update: clear on accept, add when a tagged product emerges.
  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (tag_q[ALU_LAT-1]) begin
      acc_d = acc_q + ACC_W'(alu_result);
    end
  end

  // Tag pipe mirrors the ALU latency so only our own products are summed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      acc_q <= '0;
    end else begin
      tag_q <= ALU_LAT'({tag_q, issue});
      acc_q <= acc_d;
    end
  end

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
Sequencer that time-multiplexes the shared 16x16 ALU to compute one FIR output per accepted input sample. It owns the sample delay line, the coefficient registers and a wide accumulator. For each tap it issues one unsigned multiply to the ALU and accumulates the returned products locally. It sits between the sample stream source and the output sink, with the ALU instantiated beside it at the FIR core top level.

Parameters:
NTAPS, 8, number of taps / coefficients (>=2)
ALU_LAT, 2, cycles from ALU operands presented to product visible on alu_result
ACC_W, 35, accumulator/output width (32 + clog2(NTAPS))

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  sample valid
in_ready  out  1  high only in IDLE
in_data  in  16  unsigned sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NTAPS)  coefficient index
coef_wdata  in  16  unsigned coefficient
coef_ready  out  1  high only in IDLE; writes with coef_ready low are dropped
out_valid  out  1  FIR result valid
out_ready  in  1  sink accepts
out_data  out  ACC_W  FIR result
out_sat  out  1  saturation indicator (feature only)
alu_op_sel  out  2  to ALU op_sel
alu_a  out  16  to ALU a
alu_b  out  16  to ALU b
alu_result  in  32  from ALU result

Behaviour:
- Reset is asynchronous on rst_n low. State goes to IDLE. Delay line, coefficients, accumulator, tap counter and tag pipe clear to 0. Outputs in_ready=1 and coef_ready=1. out_valid=0, out_data=0, out_sat=0, alu_a=alu_b=0, alu_op_sel=2'b10 (NOP; ALU default branch yields 0).
- FSM states: IDLE, ISSUE, DRAIN, OUT.
- IDLE:
  - in_valid&&in_ready: shift the delay line (x[0]<=in_data, x[i]<=x[i-1]), clear acc, k<=0, go to ISSUE.
  - A coef_we in the same cycle as sample acceptance is still written.
- ISSUE, one cycle per tap, k=0..NTAPS-1:
  - Drive alu_op_sel=2'b01, alu_a=x[k], alu_b=coef[k].
  - Push tag=1 into an ALU_LAT-deep tag shift register; otherwise push 0.
  - After k==NTAPS-1, go to DRAIN.
- DRAIN: hold alu_op_sel=2'b01 (the ALU applies op_sel at its second stage) for ALU_LAT cycles, then go to OUT.
- Accumulate: whenever the tag emerging from the tag pipe is 1, acc <= acc + zero-extended alu_result. Arithmetic is unsigned; wrap at ACC_W (no overflow is possible for the default ACC_W).
- OUT:
  - out_valid=1 and out_data=acc, both held stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE.
  - A new sample may be accepted in the cycle after the handshake, not the same cycle.
- Latency: sample accepted in cycle 0 produces out_valid in cycle NTAPS+ALU_LAT+1 (11 at defaults). Throughput is one result per NTAPS+ALU_LAT+2 cycles with out_ready held high.
- Outside ISSUE/DRAIN: alu_op_sel=2'b10, and operands hold their last values.
- Reset mid-operation: the state machine aborts and no partial result is emitted. The tag pipe clears, so stale ALU pipeline contents are never accumulated.
- coef_addr >= NTAPS: the write is ignored.

Optional Feature:
FIR_SAT_EN:
- Defined: in OUT, if acc > 32'hFFFF_FFFF, out_data is 32'hFFFF_FFFF zero-extended to ACC_W and out_sat=1. Otherwise out_data=acc and out_sat=0. out_sat is valid only with out_valid.
- Undefined: out_data=acc, and out_sat is tied 0.

Decomposition:
- Shared package fir_pkg holds:
  - state enum (IDLE/ISSUE/DRAIN/OUT)
  - ALU opcode constants ALU_OP_ADD=2'b00, ALU_OP_MUL=2'b01, ALU_OP_NOP=2'b10
  - default NTAPS/ALU_LAT/ACC_W constants
- One sub-module: fir_coef_rf, an NTAPS x 16 coefficient register file with a write port gated by coef_ready and a combinational read by tap index.
- Delay line, FSM and accumulator stay in fir_mac_seq.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, in_ready=1, coef_ready=1, alu_op_sel=2'b10, out_data=0.
- Impulse, coef[k]=k+1, samples 1,0,0,0,0,0,0,0 -> out_data sequence 1,2,3,4,5,6,7,8. First out_valid exactly 11 cycles after the first accept.
- Back-pressure: hold out_ready=0 for 5 cycles in OUT -> out_data stable, in_ready=0, in_valid ignored. Release -> IDLE the next cycle.
- Full scale, all coef=0xFFFF, eight samples 0xFFFF -> eighth out_data=35'h7_FFF0_0008. With FIR_SAT_EN -> out_data=0xFFFF_FFFF and out_sat=1.
- Reset during ISSUE (k=4), then coef[0]=3 and other coefficients 0, sample 5 -> out_data=15, with no leftover partial sum.
- coef_we with coef[2]=0x10 while in ISSUE -> dropped; the next result uses the old coef[2].
